// File: rtl/v_mem_pkg.sv
// Shared encodings for the vector memory sequencer: element count, access widths, FSM states.
package v_mem_pkg;

  localparam int NELEM = 4;
  localparam int IDX_W = 2;

  localparam logic [2:0] WIDTH_BYTE = 3'b000;
  localparam logic [2:0] WIDTH_HALF = 3'b101;
  localparam logic [2:0] WIDTH_WORD = 3'b110;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } state_e;

  function automatic logic width_legal(input logic [2:0] w);
    return (w == WIDTH_BYTE) || (w == WIDTH_HALF) || (w == WIDTH_WORD);
  endfunction

endpackage

// File: rtl/v_mem_lane.sv
// Per-element address generation, byte enables, store lane replication and load lane extraction.
module v_mem_lane
  import v_mem_pkg::*;
#(
  parameter int AW = 32
) (
  input  logic [AW-1:0]    base,
  input  logic [AW-1:0]    stride,
  input  logic             strided,
  input  logic [2:0]       width,
  input  logic [IDX_W-1:0] idx,
  input  logic [31:0]      elem_wdata,
  input  logic [31:0]      mem_rdata,
  output logic [AW-1:0]    addr,
  output logic [3:0]       be,
  output logic [31:0]      wdata,
  output logic [31:0]      ld_data,
  output logic             misaligned
);

  logic [AW-1:0] step;
  logic [AW-1:0] ea;
  logic [1:0]    off;
  logic [31:0]   shifted;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    step       = AW'(1);
    be         = 4'b0000;
    wdata      = 32'h0;
    ld_data    = 32'h0;
    misaligned = 1'b0;

    if (strided) step = stride;
    else if (width == WIDTH_WORD) step = AW'(4);
    else if (width == WIDTH_HALF) step = AW'(2);

    // Wraps modulo 2^AW, so a negative stride in two's complement walks downward.
    ea      = base + step * AW'(idx);
    off     = ea[1:0];
    addr    = {ea[AW-1:2], 2'b00};
    shifted = mem_rdata >> {off, 3'b000};

    case (width)
      WIDTH_BYTE: begin
        be      = 4'b0001 << off;
        wdata   = {4{elem_wdata[7:0]}};
        ld_data = {24'h0, shifted[7:0]};
      end
      WIDTH_HALF: begin
        be         = 4'b0011 << {off[1], 1'b0};
        wdata      = {2{elem_wdata[15:0]}};
        ld_data    = {16'h0, shifted[15:0]};
        misaligned = off[0];
      end
      WIDTH_WORD: begin
        be         = 4'b1111;
        wdata      = elem_wdata;
        ld_data    = shifted;
        misaligned = (off != 2'b00);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/v_mem_seq.sv
// Vector memory sequencer: splits a 4-element load/store into single-word memory transactions.
// Optional build macro VMEM_SEQ_ALIGN_CHK_EN stops at the first misaligned element and raises err.
module v_mem_seq #(
  parameter int NELEM = v_mem_pkg::NELEM,
  parameter int AW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_store,
  input  logic [2:0]    req_width,
  input  logic [1:0]    req_mop,
  input  logic [AW-1:0] req_base,
  input  logic [AW-1:0] req_stride,
  input  logic [127:0]  req_wdata,
  output logic          mem_valid,
  input  logic          mem_ready,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [3:0]    mem_be,
  output logic [31:0]   mem_wdata,
  input  logic          mem_rvalid,
  input  logic [31:0]   mem_rdata,
  output logic          done,
  output logic [127:0]  rdata,
  output logic          err
);

  import v_mem_pkg::*;

  localparam logic [IDX_W-1:0] LAST = IDX_W'(NELEM - 1);

  state_e           state;
  logic [IDX_W-1:0] idx;
  logic             err_q;
  logic             store_q;
  logic             strided_q;
  logic [2:0]       width_q;
  logic [AW-1:0]    base_q;
  logic [AW-1:0]    stride_q;
  logic [127:0]     wdata_q;
  logic [31:0]      ld_data;
  logic             misaligned;
  logic             block;
  logic             accept;

  // Only mop[1] (strided vs unit-stride) affects addressing.
  logic unused_mop;
  assign unused_mop = req_mop[0];

  v_mem_lane #(.AW(AW)) u_lane (
    .base       (base_q),
    .stride     (stride_q),
    .strided    (strided_q),
    .width      (width_q),
    .idx        (idx),
    .elem_wdata (wdata_q[{idx, 5'b00000} +: 32]),
    .mem_rdata  (mem_rdata),
    .addr       (mem_addr),
    .be         (mem_be),
    .wdata      (mem_wdata),
    .ld_data    (ld_data),
    .misaligned (misaligned)
  );

`ifdef VMEM_SEQ_ALIGN_CHK_EN
  assign block = misaligned;
  assign err   = err_q;
`else
  logic unused_chk;
  assign unused_chk = misaligned ^ err_q;
  assign block      = 1'b0;
  assign err        = 1'b0;
`endif

  assign accept    = (state == IDLE) && req_valid && !rst;
  assign req_ready = (state == IDLE) && !rst;
  assign mem_valid = (state == ISSUE) && !block && !rst;
  assign mem_we    = store_q;
  assign done      = (state == DONE) && !rst;

  // NOTE: request fields are pure datapath, captured on acceptance before use, so they carry no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      store_q   <= req_store;
      strided_q <= req_mop[1];
      width_q   <= req_width;
      base_q    <= req_base;
      stride_q  <= req_stride;
      wdata_q   <= req_wdata;
    end
  end

  // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
      rdata <= '0;
      err_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            idx   <= '0;
            rdata <= '0;
            err_q <= 1'b0;
            state <= width_legal(req_width) ? ISSUE : DONE;
          end
        end
        ISSUE: begin
          if (block) begin
            err_q <= 1'b1;
            state <= DONE;
          end else if (mem_ready) begin
            if (!store_q)          state <= WAIT;
            else if (idx == LAST)  state <= DONE;
            else                   idx   <= idx + 1'b1;
          end
        end
        WAIT: begin
          if (mem_rvalid) begin
            rdata[{idx, 5'b00000} +: 32] <= ld_data;
            if (idx == LAST) begin
              state <= DONE;
            end else begin
              idx   <= idx + 1'b1;
              state <= ISSUE;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_v_mem_seq.sv
// Self-checking bench for v_mem_seq: directed scenarios plus random requests against a behavioural model.
module tb_v_mem_seq;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid;
  logic         req_ready;
  logic         req_store;
  logic [2:0]   req_width;
  logic [1:0]   req_mop;
  logic [31:0]  req_base;
  logic [31:0]  req_stride;
  logic [127:0] req_wdata;
  logic         mem_valid;
  logic         mem_ready;
  logic         mem_we;
  logic [31:0]  mem_addr;
  logic [3:0]   mem_be;
  logic [31:0]  mem_wdata;
  logic         mem_rvalid;
  logic [31:0]  mem_rdata;
  logic         done;
  logic [127:0] rdata;
  logic         err;

  int checks = 0;
  int errors = 0;

`ifdef VMEM_SEQ_ALIGN_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  v_mem_seq #(.NELEM(4), .AW(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_store  (req_store),
    .req_width  (req_width),
    .req_mop    (req_mop),
    .req_base   (req_base),
    .req_stride (req_stride),
    .req_wdata  (req_wdata),
    .mem_valid  (mem_valid),
    .mem_ready  (mem_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_be     (mem_be),
    .mem_wdata  (mem_wdata),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .done       (done),
    .rdata      (rdata),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---- behavioural model ----
  function automatic bit m_legal(input logic [2:0] w);
    return (w == 3'b000) || (w == 3'b101) || (w == 3'b110);
  endfunction

  function automatic logic [31:0] m_addr(input logic [31:0] base, input logic [31:0] stride,
                                         input logic [1:0] mop, input logic [2:0] w, input int i);
    logic [31:0] step;
    if (mop[1])           step = stride;
    else if (w == 3'b110) step = 32'd4;
    else if (w == 3'b101) step = 32'd2;
    else                  step = 32'd1;
    return base + step * 32'(i);
  endfunction

  function automatic bit m_mis(input logic [2:0] w, input logic [31:0] a);
    if (w == 3'b101) return a[0];
    if (w == 3'b110) return a[1:0] != 2'b00;
    return 1'b0;
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] w, input logic [31:0] a);
    if (w == 3'b110) return 4'hF;
    if (w == 3'b101) return a[1] ? 4'b1100 : 4'b0011;
    case (a[1:0])
      2'd0: return 4'b0001;
      2'd1: return 4'b0010;
      2'd2: return 4'b0100;
      default: return 4'b1000;
    endcase
  endfunction

  function automatic logic [31:0] m_wd(input logic [2:0] w, input logic [31:0] d);
    if (w == 3'b110) return d;
    if (w == 3'b101) return {d[15:0], d[15:0]};
    return {d[7:0], d[7:0], d[7:0], d[7:0]};
  endfunction

  function automatic logic [31:0] m_ld(input logic [2:0] w, input logic [31:0] a, input logic [31:0] rd);
    logic [31:0] s;
    s = rd >> (8 * a[1:0]);
    if (w == 3'b110) return s;
    if (w == 3'b101) return s & 32'h0000_FFFF;
    return s & 32'h0000_00FF;
  endfunction

  // One request: drives it, plays the memory, and compares every transaction plus the result.
  // rst_elem >= 0 asserts reset while waiting for that element's read data.
  task automatic run_req(input string name, input logic st, input logic [2:0] w, input logic [1:0] mop,
                         input logic [31:0] base, input logic [31:0] stride, input logic [127:0] wd,
                         input int stall, input bit rnd, input int rst_elem);
    logic [127:0] exp_rd;
    logic [31:0]  a, rd, d;
    bit           exp_err, waiting, fin, aborted;
    int           n, i, lat, cyc, stall_left;

    exp_rd = '0; waiting = 0; fin = 0; aborted = 0; i = 0; lat = 0; cyc = 0; stall_left = stall;
    n = 0;
    if (m_legal(w)) begin
      n = 4;
      for (int k = 0; k < 4; k++)
        if (CHK && m_mis(w, m_addr(base, stride, mop, w, k))) begin n = k; break; end
    end
    exp_err = CHK && m_legal(w) && (n < 4);

    @(negedge clk);
    #1 check({name, ":req_ready"}, req_ready, 1'b1);
    req_valid = 1; req_store = st; req_width = w; req_mop = mop;
    req_base = base; req_stride = stride; req_wdata = wd;
    @(negedge clk);
    req_valid = 0;
    req_store = ~st; req_width = 3'($urandom); req_mop = 2'($urandom);
    req_base = $urandom; req_stride = $urandom; req_wdata = {4{$urandom}};

    while (!fin && !aborted) begin
      mem_ready = 0; mem_rvalid = 0; mem_rdata = $urandom;
      #1;
      if (done) begin
        fin = 1;
      end else if (cyc > 300) begin
        check({name, ":timeout_done"}, done, 1'b1);
        aborted = 1;
      end else if (waiting) begin
        if (rst_elem == i) begin
          rst = 1; mem_rvalid = 1;
          #1 check({name, ":rst_req_ready"}, req_ready, 1'b0);
          check({name, ":rst_mem_valid"}, mem_valid, 1'b0);
          check({name, ":rst_done"}, done, 1'b0);
          @(negedge clk);
          rst = 0; mem_rvalid = 1;
          #1 check({name, ":post_rst_req_ready"}, req_ready, 1'b1);
          check({name, ":post_rst_rdata"}, rdata, 128'h0);
          for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            mem_rvalid = 0;
            #1 check({name, ":post_rst_no_done"}, done, 1'b0);
            check({name, ":post_rst_idle"}, {mem_valid, req_ready}, 2'b01);
          end
          aborted = 1;
        end else begin
          mem_ready = rnd ? 1'($urandom) : 1'b0;
          if (lat == 0) begin
            rd = $urandom;
            mem_rvalid = 1; mem_rdata = rd;
            exp_rd[32*i +: 32] = m_ld(w, a, rd);
            waiting = 0; i++;
          end else begin
            lat--;
          end
        end
      end else begin
        a = m_addr(base, stride, mop, w, i);
        if (i >= n) begin
          check({name, ":no_issue"}, mem_valid, 1'b0);
        end else if (!mem_valid) begin
          check({name, ":mem_valid"}, mem_valid, 1'b1);
        end else begin
          check({name, ":addr"}, mem_addr, {a[31:2], 2'b00});
          check({name, ":we"}, mem_we, st);
          check({name, ":be"}, mem_be, m_be(w, a));
          if (st) begin
            d = wd[32*i +: 32];
            check({name, ":wdata"}, mem_wdata, m_wd(w, d));
          end
          mem_rvalid = rnd ? 1'($urandom) : 1'b0;
          if (stall_left > 0) stall_left--;
          else mem_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
          if (mem_ready) begin
            if (st) i++;
            else begin
              waiting = 1;
              lat = rnd ? $urandom_range(0, 3) : 0;
            end
          end
        end
      end
      cyc++;
      if (!fin && !aborted) @(negedge clk);
    end

    if (fin) begin
      check({name, ":elements"}, i, n);
      check({name, ":rdata"}, rdata, exp_rd);
      check({name, ":err"}, err, exp_err);
      @(negedge clk);
      mem_rvalid = 0; mem_ready = 0;
      #1 check({name, ":done_pulse"}, done, 1'b0);
      check({name, ":idle_ready"}, req_ready, 1'b1);
      check({name, ":rdata_hold"}, rdata, exp_rd);
      check({name, ":err_hold"}, err, exp_err);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] wsel [8];
    logic [31:0] stride;
    wsel = '{3'b000, 3'b101, 3'b110, 3'b110, 3'b101, 3'b000, 3'b011, 3'b111};

    rst = 1; req_valid = 0; req_store = 0; req_width = 0; req_mop = 0;
    req_base = 0; req_stride = 0; req_wdata = 0;
    mem_ready = 0; mem_rvalid = 0; mem_rdata = 0;
    repeat (3) @(negedge clk);
    #1 check("reset:req_ready", req_ready, 1'b0);
    check("reset:mem_valid", mem_valid, 1'b0);
    check("reset:done", done, 1'b0);
    check("reset:err", err, 1'b0);
    check("reset:rdata", rdata, 128'h0);
    rst = 0;
    #1 check("reset:release_ready", req_ready, 1'b1);

    run_req("unit_word_load", 1'b0, 3'b110, 2'b00, 32'h100, 32'h0, 128'h0, 0, 1'b0, -1);
    run_req("stride_byte_store", 1'b1, 3'b000, 2'b10, 32'h201, 32'h10,
            128'h444444A4_333333B3_222222C2_111111D1, 0, 1'b0, -1);
    run_req("neg_half_load_stall", 1'b0, 3'b101, 2'b10, 32'h6, 32'hFFFF_FFFE, 128'h0, 3, 1'b0, -1);
    run_req("misaligned_word", 1'b0, 3'b110, 2'b00, 32'h2, 32'h0, 128'h0, 0, 1'b0, -1);
    run_req("illegal_width", 1'b0, 3'b011, 2'b00, 32'h40, 32'h0, 128'h0, 0, 1'b0, -1);
    run_req("rst_in_wait", 1'b0, 3'b110, 2'b00, 32'h300, 32'h0, 128'h0, 0, 1'b0, 2);
    run_req("after_rst", 1'b0, 3'b110, 2'b10, 32'h400, 32'h0, 128'h0, 0, 1'b1, -1);
    run_req("half_store_stride0", 1'b1, 3'b101, 2'b11, 32'h12, 32'h0,
            128'hDEAD_BEEF_CAFE_F00D_0123_4567_89AB_CDEF, 1, 1'b1, -1);

    for (int r = 0; r < 40; r++) begin
      stride = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 16)) - 32'd8;
      run_req($sformatf("rand%0d", r), 1'($urandom), wsel[$urandom_range(0, 7)], 2'($urandom),
              $urandom, stride, {$urandom, $urandom, $urandom, $urandom},
              $urandom_range(0, 2), 1'b1, -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
